// File: rtl/alu_defs.sv
// Shared ALU definitions: datapath widths, ALUOp encodings and the result-slot state type.
package alu_defs;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [OP_W-1:0] ALU_SRL = 3'b100;
  localparam logic [OP_W-1:0] ALU_SRA = 3'b101;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU shared by the arbiter; unassigned opcodes produce zero.
module alu
  import alu_defs::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [OP_W-1:0]   i_op,
  output logic [DATA_W-1:0] o_c
);

  // NOTE: the default before the case keeps every path assigned, so no latch is inferred.
  always_comb begin
    o_c = '0;
    case (i_op)
      ALU_ADD: o_c = i_a + i_b;
      ALU_SUB: o_c = i_a - i_b;
      ALU_AND: o_c = i_a & i_b;
      ALU_OR:  o_c = i_a | i_b;
      ALU_SRL: o_c = i_a >> i_b[4:0];
      ALU_SRA: o_c = $signed(i_a) >>> i_b[4:0];
      default: o_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, else first set request below ptr.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDW   = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [IDW-1:0]   gnt_idx,
  output logic             any
);

  // NOTE: blocking assignments here are intentional; 'any' must be seen by later loop iterations.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!any && req[j] && (j >= int'(ptr))) begin
        any           = 1'b1;
        gnt_idx       = IDW'(j);
        gnt_onehot[j] = 1'b1;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!any && req[j] && (j < int'(ptr))) begin
        any           = 1'b1;
        gnt_idx       = IDW'(j);
        gnt_onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N_REQ requesters with round-robin grants and a single registered result slot.
module alu_arbiter
  import alu_defs::*;
#(
  parameter int N_REQ = 2,
  parameter int IDW   = 1,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_c,
  output logic [IDW-1:0]          rsp_id,
  output logic [CNT_W-1:0]        ops_done
);

  slot_state_e       r_state;
  slot_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_c;
  logic [IDW-1:0]    r_id;
  logic [IDW-1:0]    r_ptr;
  logic [CNT_W-1:0]  r_ops;

  logic [N_REQ-1:0]  w_onehot;
  logic [IDW-1:0]    w_gnt_idx;
  logic              w_any;
  logic              w_slot_free;
  logic              w_grant;
  logic              w_rsp_fire;
  logic [IDW-1:0]    w_ptr_nxt;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [OP_W-1:0]   w_op;
  logic [DATA_W-1:0] w_alu_c;

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req        (req_valid),
    .ptr        (r_ptr),
    .gnt_onehot (w_onehot),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_op = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_gnt_idx == IDW'(j)) begin
        w_a  = req_a[j*DATA_W +: DATA_W];
        w_b  = req_b[j*DATA_W +: DATA_W];
        w_op = req_op[j*OP_W +: OP_W];
      end
    end
  end

  alu u_alu (
    .i_a  (w_a),
    .i_b  (w_b),
    .i_op (w_op),
    .o_c  (w_alu_c)
  );

  assign rsp_valid   = (r_state == ST_FULL);
  assign w_slot_free = !rsp_valid || rsp_ready;
  // Reset gates the grant so no requester sees a handshake that the slot would then drop.
  assign w_grant     = w_any && w_slot_free && !reset;
  assign w_rsp_fire  = rsp_valid && rsp_ready;
  assign req_ready   = w_grant ? w_onehot : '0;
  assign w_ptr_nxt   = (w_gnt_idx == IDW'(N_REQ - 1)) ? '0 : w_gnt_idx + IDW'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_grant) w_state_nxt = ST_FULL;
      ST_FULL:  if (rsp_ready) w_state_nxt = w_grant ? ST_FULL : ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_c     <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
      r_ops   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_c   <= w_alu_c;
        r_id  <= w_gnt_idx;
        r_ptr <= w_ptr_nxt;
      end
      if (w_rsp_fire) r_ops <= r_ops + CNT_W'(1);
    end
  end

  assign rsp_c    = r_c;
  assign rsp_id   = r_id;
  assign ops_done = r_ops;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, counter-wrap sequence, random run vs reference model.
module tb_alu_arbiter;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N*3-1:0]  req_op;
  logic          rsp_ready;

  logic [N-1:0]  req_ready,  req_ready4;
  logic          rsp_valid,  rsp_valid4;
  logic [31:0]   rsp_c,      rsp_c4;
  logic          rsp_id,     rsp_id4;
  logic [15:0]   ops_done;
  logic [3:0]    ops_done4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N_REQ(2), .IDW(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_id(rsp_id), .ops_done(ops_done)
  );

  alu_arbiter #(.N_REQ(2), .IDW(1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready4),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid4),
    .rsp_ready(rsp_ready), .rsp_c(rsp_c4), .rsp_id(rsp_id4), .ops_done(ops_done4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU behaviour written from the opcode definitions, independent of the RTL.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [31:0] r;
    int          s;
    s = int'(b[4:0]);
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a >> s;
      3'd5: begin
        r = a >> s;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
      end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Reference model: slot occupancy, result, owner, completed count, round-robin start index.
  bit          m_valid = 1'b0;
  logic [31:0] m_c     = '0;
  logic        m_id    = 1'b0;
  int          m_cnt   = 0;
  int          m_ptr   = 0;
  logic [N-1:0] last_rdy = '0;

  task automatic tick(output logic [N-1:0] rdy_seen);
    int          win;
    int          j;
    logic [N-1:0] e_rdy;
    logic        rst_seen;
    logic [31:0] a_sel, b_sel;
    logic [2:0]  op_sel;
    @(negedge clk);
    win = -1;
    if (!reset && (!m_valid || rsp_ready)) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (win < 0 && req_valid[j]) win = j;
      end
    end
    e_rdy = (win < 0) ? '0 : N'(1 << win);
    check("req_ready", {62'd0, req_ready}, {62'd0, e_rdy});
    check("req_ready_cnt4", {62'd0, req_ready4}, {62'd0, e_rdy});
    rdy_seen = req_ready;
    last_rdy = e_rdy;
    rst_seen = reset;
    if (reset) begin
      m_valid = 1'b0; m_c = '0; m_id = 1'b0; m_cnt = 0; m_ptr = 0;
    end else begin
      if (m_valid && rsp_ready) begin
        m_cnt++;
        m_valid = 1'b0;
      end
      if (win >= 0) begin
        a_sel  = (win == 0) ? req_a[31:0] : req_a[63:32];
        b_sel  = (win == 0) ? req_b[31:0] : req_b[63:32];
        op_sel = (win == 0) ? req_op[2:0] : req_op[5:3];
        m_valid = 1'b1;
        m_c     = alu_ref(a_sel, b_sel, op_sel);
        m_id    = 1'(win);
        m_ptr   = (win + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    check("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_valid});
    check("rsp_valid_cnt4", {63'd0, rsp_valid4}, {63'd0, m_valid});
    check("ops_done", {48'd0, ops_done}, {48'd0, 16'(m_cnt)});
    check("ops_done_cnt4", {60'd0, ops_done4}, {60'd0, 4'(m_cnt)});
    if (m_valid || rst_seen) begin
      check("rsp_c", {32'd0, rsp_c}, {32'd0, m_c});
      check("rsp_id", {63'd0, rsp_id}, {63'd0, m_id});
      check("rsp_c_cnt4", {32'd0, rsp_c4}, {32'd0, m_c});
      check("rsp_id_cnt4", {63'd0, rsp_id4}, {63'd0, m_id});
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [31:0] a0, b0;
    logic [2:0]  op0;
    logic [31:0] a1, b1;
    logic [2:0]  op1;
    logic        rdy;
    logic [1:0]  e_ready;
    logic        e_valid;
    logic [31:0] e_c;
    logic        e_id;
    logic [15:0] e_ops;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [1:0] valid, input logic [31:0] a1,
                              input logic [31:0] b1, input logic rdy, input logic [1:0] e_ready,
                              input logic e_valid, input logic [31:0] e_c, input logic e_id,
                              input logic [15:0] e_ops);
    vec_t v;
    v.rst = rst; v.valid = valid;
    v.a0 = 32'd3; v.b0 = 32'd5; v.op0 = 3'b000;
    v.a1 = a1;    v.b1 = b1;    v.op1 = 3'b001;
    v.rdy = rdy;  v.e_ready = e_ready; v.e_valid = e_valid;
    v.e_c = e_c;  v.e_id = e_id; v.e_ops = e_ops;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin : main
    logic [N-1:0] seen;

    // reset with all requests valid, single op, alternating stream, backpressure, reset while full
    tbl[0]  = mk(1, 2'b11, 10, 3, 1, 2'b00, 0, 0,  0, 0);
    tbl[1]  = mk(1, 2'b11, 10, 3, 1, 2'b00, 0, 0,  0, 0);
    tbl[2]  = mk(0, 2'b01, 10, 3, 1, 2'b01, 1, 8,  0, 0);
    tbl[3]  = mk(1, 2'b00, 10, 3, 1, 2'b00, 0, 0,  0, 0);
    tbl[4]  = mk(0, 2'b11, 10, 3, 1, 2'b01, 1, 8,  0, 0);
    tbl[5]  = mk(0, 2'b11, 10, 3, 1, 2'b10, 1, 7,  1, 1);
    tbl[6]  = mk(0, 2'b11, 10, 3, 1, 2'b01, 1, 8,  0, 2);
    tbl[7]  = mk(0, 2'b11, 10, 3, 1, 2'b10, 1, 7,  1, 3);
    tbl[8]  = mk(0, 2'b00, 10, 3, 1, 2'b00, 0, 0,  0, 4);
    tbl[9]  = mk(0, 2'b10, 10, 3, 1, 2'b10, 1, 7,  1, 4);
    for (int i = 10; i < 15; i++)
      tbl[i] = mk(0, 2'b10, 20, 6, 0, 2'b00, 1, 7, 1, 4);
    tbl[15] = mk(0, 2'b10, 20, 6, 1, 2'b10, 1, 14, 1, 5);
    tbl[16] = mk(1, 2'b11, 20, 6, 1, 2'b00, 0, 0,  0, 0);
    tbl[17] = mk(0, 2'b11, 20, 6, 0, 2'b01, 1, 8,  0, 0);
    tbl[18] = mk(0, 2'b10, 20, 6, 1, 2'b10, 1, 14, 1, 1);
    tbl[19] = mk(0, 2'b00, 20, 6, 1, 2'b00, 0, 0,  0, 2);

    for (int i = 0; i < 20; i++) begin
      reset     = tbl[i].rst;
      req_valid = tbl[i].valid;
      req_a     = {tbl[i].a1, tbl[i].a0};
      req_b     = {tbl[i].b1, tbl[i].b0};
      req_op    = {tbl[i].op1, tbl[i].op0};
      rsp_ready = tbl[i].rdy;
      tick(seen);
      check($sformatf("vec%0d.req_ready", i), {62'd0, seen}, {62'd0, tbl[i].e_ready});
      check($sformatf("vec%0d.rsp_valid", i), {63'd0, rsp_valid}, {63'd0, tbl[i].e_valid});
      check($sformatf("vec%0d.ops_done", i), {48'd0, ops_done}, {48'd0, tbl[i].e_ops});
      if (tbl[i].e_valid || tbl[i].rst) begin
        check($sformatf("vec%0d.rsp_c", i), {32'd0, rsp_c}, {32'd0, tbl[i].e_c});
        check($sformatf("vec%0d.rsp_id", i), {63'd0, rsp_id}, {63'd0, tbl[i].e_id});
      end
    end

    // 4-bit counter wrap: 16 responses bring it back to 0, the 17th makes it 1.
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    tick(seen);
    reset = 1'b0; req_valid = 2'b01;
    req_a = {32'd0, 32'd1}; req_b = {32'd0, 32'd1}; req_op = 6'd0;
    for (int i = 0; i < 17; i++) tick(seen);
    check("wrap16.ops_done_cnt4", {60'd0, ops_done4}, 64'd0);
    check("wrap16.ops_done", {48'd0, ops_done}, 64'd16);
    req_valid = 2'b00;
    tick(seen);
    check("wrap17.ops_done_cnt4", {60'd0, ops_done4}, 64'd1);

    // Random traffic; requesters hold their request until granted.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset     = ($urandom_range(0, 99) == 0);
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !last_rdy[i])) begin
          req_valid[i]       = ($urandom_range(0, 2) != 0);
          req_a[i*32 +: 32]  = $urandom;
          req_b[i*32 +: 32]  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
          req_op[i*3 +: 3]   = 3'($urandom_range(0, 7));
        end
      end
      tick(seen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
